// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the host byte-stream program loader.
// Optional checksum support is selected with LOADER_CHKSUM_EN.
package prog_loader_pkg;

    localparam int         DPW            = 32;
    localparam logic [7:0] LOADER_SYNC    = 8'hA5;
    localparam int         LOADER_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_DATA,
`ifdef LOADER_CHKSUM_EN
        S_CHK,
`endif
        S_DONE
    } loader_state_e;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Little-endian byte-to-word assembler: the word is presented combinationally
// together with its 4th byte so the parent can register the write that cycle.
module loader_word_asm
    import prog_loader_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_srst,
    input  logic           i_clr,
    input  logic           i_en,
    input  logic [7:0]     i_byte,
    output logic           o_word_valid,
    output logic [DPW-1:0] o_word
);
    logic [DPW-9:0] r_sh;
    logic [1:0]     r_cnt;

    assign o_word_valid = i_en && (r_cnt == 2'd3);
    assign o_word       = {i_byte, r_sh};

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clr) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_en) begin
            r_sh  <= {i_byte, r_sh[DPW-9:8]};
            r_cnt <= r_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Framed host-byte loader driving the core memory-load port and core_hold.
// Define LOADER_CHKSUM_EN to expect and verify a trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = LOADER_SYNC,
    parameter int         TIMEOUT_CYC = LOADER_TIMEOUT
) (
    input  logic           i_clk,
    input  logic           i_srst,
    input  logic           i_byte_valid,
    input  logic [7:0]     i_byte_data,
    output logic           o_byte_ready,
    output logic           o_data_en,
    output logic [DPW-1:0] o_input_addr,
    output logic [DPW-1:0] o_input_data,
    output logic           o_core_hold,
    output logic           o_busy,
    output logic           o_load_done,
    output logic           o_load_err
);
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
`ifdef LOADER_CHKSUM_EN
    localparam loader_state_e S_END = S_CHK;
`else
    localparam loader_state_e S_END = S_DONE;
`endif

    loader_state_e  r_state, w_next;
    logic [1:0]     r_idx;
    logic [DPW-1:0] r_addr;
    logic [15:0]    r_cnt;
    logic [TW-1:0]  r_tmo;
    logic           r_data_en, r_core_hold, r_load_err;
    logic [DPW-1:0] r_input_addr, r_input_data;
    logic           w_acc, w_sync, w_in_frame, w_tmo, w_word_valid, w_chk_bad;
    logic [DPW-1:0] w_word;
    logic [15:0]    w_cnt_full;

    assign o_byte_ready = !i_srst;
    assign w_acc        = i_byte_valid && o_byte_ready;
    assign w_sync       = w_acc && (i_byte_data == SYNC_BYTE);
    assign w_in_frame   = (r_state != S_IDLE) && (r_state != S_DONE);
    // An accepted byte in the expiry cycle keeps the frame alive.
    assign w_tmo        = w_in_frame && !w_acc && (r_tmo == TMO_LAST);
    assign w_cnt_full   = {i_byte_data, r_cnt[15:8]};

    loader_word_asm u_asm (
        .i_clk        (i_clk),
        .i_srst       (i_srst),
        .i_clr        (r_state != S_DATA),
        .i_en         (w_acc && (r_state == S_DATA)),
        .i_byte       (i_byte_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

`ifdef LOADER_CHKSUM_EN
    logic [7:0] r_chk;
    assign w_chk_bad = (r_state == S_CHK) && w_acc && (i_byte_data != r_chk);

    always_ff @(posedge i_clk) begin
        if (i_srst || (!w_in_frame && w_sync))
            r_chk <= '0;
        else if (w_acc && w_in_frame && r_state != S_CHK)
            r_chk <= r_chk ^ i_byte_data;
    end
`else
    assign w_chk_bad = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_srst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_sync) w_next = S_ADDR;
            S_DONE: w_next = w_sync ? S_ADDR : S_IDLE;
            S_ADDR: if (w_tmo) w_next = S_IDLE;
                    else if (w_acc && r_idx == 2'd3) w_next = S_CNT;
            S_CNT:  if (w_tmo) w_next = S_IDLE;
                    else if (w_acc && r_idx == 2'd1)
                        w_next = (w_cnt_full == 16'd0) ? S_END : S_DATA;
            S_DATA: if (w_tmo) w_next = S_IDLE;
                    else if (w_word_valid && r_cnt == 16'd1) w_next = S_END;
`ifdef LOADER_CHKSUM_EN
            S_CHK:  if (w_tmo) w_next = S_IDLE;
                    else if (w_acc) w_next = w_chk_bad ? S_IDLE : S_DONE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_idx        <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_data_en    <= 1'b0;
            r_input_addr <= '0;
            r_input_data <= '0;
            r_core_hold  <= 1'b1;
            r_load_err   <= 1'b0;
        end else begin
            r_data_en <= 1'b0;
            r_tmo     <= (!w_in_frame || w_acc) ? '0 : r_tmo + TW'(1);
            r_idx     <= (w_next != r_state) ? 2'd0 : (w_acc ? r_idx + 2'd1 : r_idx);
            if (w_tmo || w_chk_bad) r_load_err <= 1'b1;
            case (r_state)
                S_IDLE, S_DONE: if (w_sync) begin
                    r_load_err  <= 1'b0;
                    r_core_hold <= 1'b1;
                end
                S_ADDR: if (w_acc)
                    r_addr <= (r_idx == 2'd3) ? {i_byte_data, r_addr[31:10], 2'b00}
                                              : {i_byte_data, r_addr[31:8]};
                S_CNT:  if (w_acc) r_cnt <= w_cnt_full;
                S_DATA: if (w_word_valid) begin
                    r_data_en    <= 1'b1;
                    r_input_addr <= r_addr;
                    r_input_data <= w_word;
                    r_addr       <= r_addr + 32'd4;
                    r_cnt        <= r_cnt - 16'd1;
                end
                default: ;
            endcase
            if (w_next == S_DONE && r_state != S_DONE) r_core_hold <= 1'b0;
        end
    end

    assign o_data_en    = r_data_en;
    assign o_input_addr = r_input_addr;
    assign o_input_data = r_input_data;
    assign o_core_hold  = r_core_hold;
    assign o_busy       = (r_state != S_IDLE);
    assign o_load_done  = (r_state == S_DONE);
    assign o_load_err   = r_load_err;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of directed frames, random frames against a
// frame-level model, plus timeout and mid-frame reset sequences.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int TMO = 1024;
`ifdef LOADER_CHKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic        clk = 1'b0, srst = 1'b1, bv = 1'b0;
    logic [7:0]  bd = 8'h00;
    logic        ready, data_en, core_hold, busy, load_done, load_err;
    logic [31:0] in_addr, in_data;

    always #5 clk = ~clk;

    prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
        .i_clk(clk), .i_srst(srst), .i_byte_valid(bv), .i_byte_data(bd),
        .o_byte_ready(ready), .o_data_en(data_en), .o_input_addr(in_addr),
        .o_input_data(in_data), .o_core_hold(core_hold), .o_busy(busy),
        .o_load_done(load_done), .o_load_err(load_err)
    );

    int checks = 0, errors = 0;
    logic [31:0] got_a[$], got_d[$];
    int n_done = 0;

    always @(negedge clk) begin
        if (data_en) begin
            got_a.push_back(in_addr);
            got_d.push_back(in_data);
        end
        if (load_done) n_done++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bv = 1'b1;
        bd = b;
        @(posedge clk);
        #1;
        bv = 1'b0;
    endtask

    // Frame-level model: bytes are built from the frame format, expected
    // writes from base/words; results compared after the frame completes.
    task automatic run_frame(input string name, input logic [31:0] base, input int n,
                             input logic [3:0][31:0] w, input bit bad, input int noise,
                             input int gapmax, input bit exp_err, input bit exp_done);
        logic [7:0] q[$];
        logic [7:0] nz[3];
        logic [7:0] chk;
        logic [31:0] ea;
        nz[0] = 8'h00; nz[1] = 8'hFF; nz[2] = 8'h5A;
        got_a.delete();
        got_d.delete();
        n_done = 0;
        for (int i = 0; i < noise; i++) send_byte(nz[i % 3]);
        idle(1);
        check({name, " noise busy"}, 64'(busy), 64'd0);
        check({name, " noise writes"}, 64'(got_a.size()), 64'd0);

        q.push_back(8'hA5);
        for (int k = 0; k < 4; k++) q.push_back(base[8*k +: 8]);
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) q.push_back(w[i][8*k +: 8]);
        chk = 8'h00;
        for (int i = 1; i < q.size(); i++) chk ^= q[i];
        if (CHK_ON) q.push_back(chk ^ {7'd0, bad});

        send_byte(q[0]);
        check({name, " sync hold"}, 64'(core_hold), 64'd1);
        check({name, " sync err clr"}, 64'(load_err), 64'd0);
        for (int i = 1; i < q.size(); i++) begin
            if (gapmax > 0) idle($urandom_range(0, gapmax));
            send_byte(q[i]);
        end
        check({name, " done pulse"}, 64'(load_done), 64'(exp_done));
        check({name, " hold after"}, 64'(core_hold), 64'(!exp_done));
        idle(3);
        check({name, " nwrites"}, 64'(got_a.size()), 64'(n));
        for (int i = 0; i < n && i < got_a.size(); i++) begin
            ea = {base[31:2], 2'b00} + 32'(4 * i);
            check({name, " addr"}, 64'(got_a[i]), 64'(ea));
            check({name, " data"}, 64'(got_d[i]), 64'(w[i]));
        end
        check({name, " ndone"}, 64'(n_done), 64'(exp_done));
        check({name, " err"}, 64'(load_err), 64'(exp_err));
        check({name, " busy end"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        string           name;
        logic [31:0]     base;
        int              n;
        logic [3:0][31:0] w;
        bit              bad;
        int              noise;
        bit              err_chk;   // expected load_err when checksum is enabled
        bit              done_chk;  // expected load_done when checksum is enabled
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [3:0][31:0] rw;
        bit rbad;
        int rn, cyc;

        tbl[0] = '{"good4",  32'h0,        4, {32'd7, 32'd6, 32'd5, 32'd4}, 1'b0, 0, 1'b0, 1'b1};
        tbl[1] = '{"badchk", 32'h0,        4, {32'd7, 32'd6, 32'd5, 32'd4}, 1'b1, 0, 1'b1, 1'b0};
        tbl[2] = '{"noise",  32'h1000,     2, {32'h0, 32'h0, 32'h01234567, 32'hDEADBEEF}, 1'b0, 3, 1'b0, 1'b1};
        tbl[3] = '{"wrap",   32'hFFFFFFFC, 2, {32'h0, 32'h0, 32'h22, 32'h11}, 1'b0, 0, 1'b0, 1'b1};
        tbl[4] = '{"mask",   32'h00000203, 1, {32'h0, 32'h0, 32'h0, 32'hCAFEF00D}, 1'b0, 1, 1'b0, 1'b1};
        tbl[5] = '{"n0",     32'h00000080, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 0, 1'b0, 1'b1};

        // Reset state
        idle(1);
        check("rst ready", 64'(ready), 64'd0);
        idle(2);
        srst = 1'b0;
        idle(1);
        check("rst ready after", 64'(ready), 64'd1);
        check("rst hold", 64'(core_hold), 64'd1);
        check("rst data_en", 64'(data_en), 64'd0);
        check("rst addr", 64'(in_addr), 64'd0);
        check("rst data", 64'(in_data), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(load_done), 64'd0);
        check("rst err", 64'(load_err), 64'd0);

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i].name, tbl[i].base, tbl[i].n, tbl[i].w, tbl[i].bad, tbl[i].noise, 0,
                      CHK_ON ? tbl[i].err_chk : 1'b0, CHK_ON ? tbl[i].done_chk : 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) rw[i] = $urandom;
            rn   = $urandom_range(0, 4);
            rbad = 1'($urandom_range(0, 1));
            run_frame("rand", $urandom, rn, rw, rbad, $urandom_range(0, 3), 2,
                      CHK_ON && rbad, !(CHK_ON && rbad));
        end

        // Timeout after two data bytes of the first word
        got_a.delete();
        got_d.delete();
        send_byte(8'hA5);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        cyc = 0;
        while (busy && cyc < TMO + 8) begin
            idle(1);
            cyc++;
        end
        check("tmo cycles in range", 64'(cyc >= TMO - 1 && cyc <= TMO + 1), 64'd1);
        check("tmo err", 64'(load_err), 64'd1);
        check("tmo busy", 64'(busy), 64'd0);
        check("tmo hold", 64'(core_hold), 64'd1);
        check("tmo writes", 64'(got_a.size()), 64'd0);
        run_frame("after_tmo", 32'h00000200, 1, {32'h0, 32'h0, 32'h0, 32'h5555AAAA}, 1'b0, 0, 0,
                  1'b0, 1'b1);

        // Reset during the 3rd byte of word 2
        got_a.delete();
        got_d.delete();
        send_byte(8'hA5);
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hAA); send_byte(8'hBB);
        bv = 1'b1; bd = 8'hCC; srst = 1'b1;
        @(posedge clk);
        #1;
        check("srst ready", 64'(ready), 64'd0);
        check("srst data_en", 64'(data_en), 64'd0);
        check("srst addr", 64'(in_addr), 64'd0);
        check("srst data", 64'(in_data), 64'd0);
        check("srst busy", 64'(busy), 64'd0);
        check("srst done", 64'(load_done), 64'd0);
        check("srst err", 64'(load_err), 64'd0);
        check("srst hold", 64'(core_hold), 64'd1);
        srst = 1'b0;
        bv = 1'b0;
        send_byte(8'hDD); send_byte(8'h01); send_byte(8'h02);
        idle(6);
        check("srst nwrites", 64'(got_a.size()), 64'd1);
        if (got_a.size() > 0) check("srst w1 addr", 64'(got_a[0]), 64'h40);
        check("srst busy idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program/data loader sitting directly upstream of the core `top`. It parses framed bytes from a host link (UART/JTAG bridge side), assembles 32-bit little-endian words, and drives the core's memory-load port (`data_en`, `input_addr`, `input_data`) with one single-cycle write per word. It holds the core in reset through `core_hold` until a frame has loaded successfully.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT_CYC`, 1024, maximum idle cycles between accepted bytes inside a frame.

Ports:
- `clk`  in  1  clock.
- `srst`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `byte_valid`  in  1  host byte present.
- `byte_data`  in  8  host byte.
- `byte_ready`  out  1  loader accepts the byte this cycle.
- `data_en`  out  1  single-cycle word write strobe to `top`.
- `input_addr`  out  DPW  word byte-address.
- `input_data`  out  DPW  word data.
- `core_hold`  out  1  high = keep core reset.
- `busy`  out  1  frame in progress.
- `load_done`  out  1  one-cycle pulse on a good frame.
- `load_err`  out  1  level; set on checksum mismatch or timeout, cleared when the next sync byte is accepted.

## Operation
- Frame: `SYNC_BYTE`, 4-byte base address (LSB first), 2-byte word count N (LSB first), 4·N data bytes (each word LSB first), then 1 checksum byte when `LOADER_CHKSUM_EN` is defined.
- A byte is accepted on `byte_valid && byte_ready`. `byte_ready` is 1 in every state except under `srst`.
- FSM states: IDLE, ADDR, CNT, DATA, CHK, DONE.
  - IDLE: non-sync bytes are accepted and discarded. A sync byte goes to ADDR, clears `load_err`, and sets `core_hold`.
  - ADDR: after 4 bytes go to CNT. Address bits [1:0] are forced to 00.
  - CNT: after 2 bytes, go to DATA if N≠0, else to CHK (or DONE when checksum is compiled out).
  - DATA: on the 4th byte of each word, register the write. After word N go to CHK/DONE.
  - CHK: one byte is compared against the running XOR. Match goes to DONE. Mismatch sets `load_err` and goes to IDLE.
  - DONE: pulse `load_done`, clear `core_hold`, return to IDLE (one cycle).
- Address increments by 4 per word and wraps mod 2^32.
- Words are written as they arrive. A later checksum failure does not undo them.
- Timeout counter:
  - Cleared on each accepted byte and in IDLE.
  - Reaching `TIMEOUT_CYC` in any non-IDLE state sets `load_err` and returns to IDLE. `core_hold` stays 1.
  - A byte accepted in the same cycle as expiry wins.
- `busy` = state ≠ IDLE.

## Timing
- Reset values:
  - `core_hold`=1.
  - `data_en`=0, `input_addr`=0, `input_data`=0.
  - `busy`=0, `load_done`=0, `load_err`=0.
  - `byte_ready`=0 during `srst`, 1 thereafter.
- `data_en` is high exactly one cycle, the cycle after the 4th byte of a word is accepted. `input_addr`/`input_data` are valid that cycle and hold until the next write.
- Back-to-back bytes every cycle are sustained. The minimum word-to-word write spacing is 4 cycles.
- `load_done` and the `core_hold` fall occur in the cycle after the final byte is accepted (checksum byte, or last data byte when checksum is compiled out).
- `srst` mid-frame aborts immediately. No write is issued for a partial word, and all outputs take their reset values the next cycle.

## Configuration
- `LOADER_CHKSUM_EN` defined:
  - Frame ends with the checksum byte, equal to the XOR of all bytes after the sync byte.
  - CHK state exists.
  - A mismatch asserts `load_err`.
- `LOADER_CHKSUM_EN` undefined:
  - No checksum byte is expected and the CHK state is absent.
  - `load_err` is raised only by timeout.

## Structure
- `rv32i_pkg` gains:
  - `loader_state_e` enum.
  - `LOADER_SYNC` (8'hA5) and `LOADER_TIMEOUT` (1024) constants, used as parameter defaults.
  - Reuses `DPW`.
- Sub-module `loader_word_asm`: byte-to-word shift register plus 2-bit byte counter, producing a `word_valid` pulse and a DPW-bit word. The FSM, address/count counters, timeout and checksum live in `prog_loader`.

## Test plan
- Good frame, checksum on: A5, 00 00 00 00, 04 00, words 4,5,6,7, chk 04 → writes (0,4),(4,5),(8,6),(C,7), one `load_done`, `core_hold` 1→0, `load_err`=0.
- Same frame with checksum 05 → the same 4 writes, `load_err`=1, no `load_done`, `core_hold` stays 1.
- Idle noise 00, FF, 5A before the frame → no writes, `busy`=0; the following frame loads normally.
- Wrap: base FFFFFFFC, N=2, words 11,22 → writes (FFFFFFFC,11),(00000000,22).
- Timeout: stop after 2 data bytes, idle `TIMEOUT_CYC` cycles → `load_err`=1, IDLE, no partial write; the next good frame clears `load_err` and completes.
- `srst` asserted during the 3rd byte of word 2 → no further `data_en`, all outputs at reset values, `core_hold`=1.
